// File: rtl/apb_pkg.sv
// ============================================================================
// Package : apb_pkg
// Purpose : Shared types and default widths for the APB master bridge.
//           Provides the one-hot FSM state enum, command/response structs
//           and the default address/data widths.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  // Default bus widths; the bridge parameters default to these.
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // One-hot state encoding so each output decode is a single flop bit.
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } apb_state_e;

  // Command as presented on the upstream valid/ready channel.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
  } apb_cmd_t;

  // Response as returned on the downstream valid/ready channel.
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module  : apb_master_bridge
// Purpose : Converts a valid/ready command stream into APB3 SETUP/ACCESS
//           transfers (single outstanding transfer) and returns one
//           response (read data + error flag) per command on a valid/ready
//           response channel. Any number of pready wait states is tolerated.
// Config  : `define APB_TIMEOUT_EN to abort an ACCESS phase after
//           TIMEOUT_CYCLES cycles of pready low (response flagged as error,
//           read data forced to 0). Without it the bridge waits forever.
// Ports   :
//   pclk, rst               clock / asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata    command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_err       response payload
//   psel/penable/pwrite     APB control
//   paddr/pwdata            APB address / write data
//   prdata/pready/pslverr   APB slave return path
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              rst,
  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB master interface
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q,  state_d;
  logic [ADDR_W-1:0] paddr_q,  paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;

  // --------------------------------------------------------------------------
  // Optional ACCESS-phase timeout
  // --------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_hit;

  // The current pready-low cycle is the TIMEOUT_CYCLES-th one when the count
  // of earlier low cycles is TIMEOUT_CYCLES-1; abort at the end of it.
  assign to_hit = (state_q == ACCESS) && !pready &&
                  (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      // Cleared before SETUP so every transfer starts from zero.
      to_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready && !to_hit) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Timeout disabled: the parameter is intentionally not used.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // pslverr only matters on the completing cycle.
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          state_d = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: control strobes decode straight from the state register so an
  // asynchronous reset drops them in the same cycle.
  // --------------------------------------------------------------------------
  // cmd_ready is also gated by rst so nothing is accepted while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule : apb_master_bridge

`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester; converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers toward the team's APB slave.
- Tolerates any number of pready wait states and captures pslverr.
- Returns one response per command (read data plus error flag) on a valid/ready response channel.
- Single outstanding transfer; sits between the bench/CPU-side sequencer and the APB bus.

Parameters:
- ADDR_W, 32, paddr/cmd_addr width
- DATA_W, 32, pwdata/prdata width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort (used only with APB_TIMEOUT_EN)

Ports:
- pclk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  pslverr or timeout on this transfer
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (async assert, sync deassert honoured by rising edge): state=IDLE; psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0. Reset mid-transfer drops psel/penable immediately; the pending command and response are discarded.
- FSM states, one-hot encoded: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1 (combinational from state). On cmd_valid & cmd_ready, latch write/addr/wdata into paddr/pwrite/pwdata and go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle. Next state is ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=0: stay in ACCESS.
  - pready=1: sample prdata (reads only; writes give 0) into rsp_rdata and pslverr into rsp_err. Deassert psel/penable next cycle and go to RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready=1. On rsp_valid & rsp_ready, go to IDLE.
- Latency with zero wait states and rsp_ready tied high: command accept to rsp_valid = 3 cycles. The next command can be accepted 1 cycle after the response handshake.
- Each wait state adds exactly 1 ACCESS cycle.
- pslverr is sampled only in the pready=1 ACCESS cycle and ignored elsewhere.
- cmd_valid while not in IDLE: ignored (cmd_ready=0); no command loss because the requester holds valid.
- psel never asserts outside SETUP/ACCESS; penable never asserts without psel.
- Address/data widths are passed through unmodified; no alignment checking.

Optional Feature:
- Macro: APB_TIMEOUT_EN
- With the macro defined: a counter increments each ACCESS cycle with pready=0 and clears on entering SETUP. When it reaches TIMEOUT_CYCLES, the transfer aborts: psel/penable deassert, rsp_err=1, rsp_rdata=0, next state RESP.
- Without the macro: no counter is instantiated and the bridge waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum (IDLE, SETUP, ACCESS, RESP)
  - apb_cmd_t struct (write, addr, data)
  - apb_rsp_t struct (rdata, err)
  - default ADDR_W/DATA_W localparams
- No sub-module. If APB_TIMEOUT_EN grows, the timeout counter may move to apb_timeout_ctr; not required now.

Test Plan:
- Zero-wait write: cmd write addr 0x4 data 0xDEAD_BEEF, pready held 1 -> one SETUP cycle, one ACCESS cycle with paddr=0x4 and pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read back: read addr 0x4 after the previous write -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states: pready low 3 cycles in ACCESS, read addr 0x10 with slave returning 0x10 -> penable high for exactly 4 cycles, paddr stable throughout; rsp_rdata=0x10.
- Slave error: write to addr 0xFFFF_FFFF with pslverr=1 at the pready cycle -> rsp_err=1. The next command, to addr 0x8, returns rsp_err=0.
- Backpressure and reset: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0. Then assert rst during a later ACCESS -> psel/penable/rsp_valid go 0 in the same cycle and the FSM returns to IDLE.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and pready stuck 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0. Without the macro, the bridge stays in ACCESS.
